// File: rtl/dvi_blue_tx.sv
// DVI blue-channel transmitter: raster timing generator plus a two-stage
// TMDS encoder. pixel_b is consumed two cycles before its encoded word
// appears on tmds_word; de/hsync/vsync/frame_start travel with the data.
module dvi_blue_tx #(
  parameter int RESOLUTION = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_b,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic [9:0]  tmds_word,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int DATA_W = 8;
  localparam bit HD     = (RESOLUTION == 720);

  localparam logic [10:0] H_ACT  = HD ? 11'd1280 : 11'd640;
  localparam logic [10:0] H_FP   = HD ? 11'd110  : 11'd16;
  localparam logic [10:0] H_SYNC = HD ? 11'd40   : 11'd96;
  localparam logic [10:0] H_TOT  = HD ? 11'd1650 : 11'd800;
  localparam logic [9:0]  V_ACT  = HD ? 10'd720  : 10'd480;
  localparam logic [9:0]  V_FP   = HD ? 10'd5    : 10'd10;
  localparam logic [9:0]  V_SYNC = HD ? 10'd5    : 10'd2;
  localparam logic [9:0]  V_TOT  = HD ? 10'd750  : 10'd525;

  localparam logic [10:0] H_HS0  = H_ACT + H_FP;
  localparam logic [10:0] H_HS1  = H_HS0 + H_SYNC;
  localparam logic [10:0] H_LAST = H_TOT - 11'd1;
  localparam logic [9:0]  V_VS0  = V_ACT + V_FP;
  localparam logic [9:0]  V_VS1  = V_VS0 + V_SYNC;
  localparam logic [9:0]  V_LAST = V_TOT - 10'd1;

  // Control tokens indexed by {vsync, hsync}
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Population count of an 8-bit value (0..8)
  function automatic logic [3:0] ones8(input logic [DATA_W-1:0] x);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < DATA_W; i++) s = s + {3'b000, x[i]};
    return s;
  endfunction

  // Transition-minimising first step of TMDS: XOR or XNOR chain, flag in bit 8
  function automatic logic [8:0] tmds_qm(input logic [DATA_W-1:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < DATA_W; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Raster counters: hcount wraps every line, vcount advances on that wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // ---- stage 0: raw timing from counters, q_m and its ones count ----
  logic       de_p0, hs_p0, vs_p0, fs_p0;
  logic [8:0] qm_p0;
  logic [3:0] n1_p0;

  assign de_p0 = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_p0 = (hcount >= H_HS0) && (hcount < H_HS1);
  assign vs_p0 = (vcount >= V_VS0) && (vcount < V_VS1);
  assign fs_p0 = (hcount == 11'd0) && (vcount == 10'd0);
  assign qm_p0 = tmds_qm(pixel_b);
  assign n1_p0 = ones8(qm_p0[7:0]);

  // ---- stage 1: registered timing, q_m and N1/N0 ----
  logic       vld_p1, hs_p1, vs_p1, fs_p1;
  logic [8:0] qm_p1;
  logic [3:0] n1_p1, n0_p1;

  // Stage-1 register; reset leaves it presenting a control-idle slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
      qm_p1  <= '0;
      n1_p1  <= '0;
      n0_p1  <= '0;
    end else begin
      vld_p1 <= de_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0;
      qm_p1  <= qm_p0;
      n1_p1  <= n1_p0;
      n0_p1  <= 4'd8 - n1_p0;
    end
  end

  // ---- stage 2: DC-balance decision and running disparity ----
  logic signed [4:0] cnt_p2, cnt_nxt;
  logic signed [5:0] n1_s, n0_s, diff, delta, cnt_sum;
  logic [9:0]        word_nxt;

  // Select control token or balanced data word and the disparity update
  always_comb begin
    n1_s     = signed'({2'b00, n1_p1});
    n0_s     = signed'({2'b00, n0_p1});
    diff     = n1_s - n0_s;
    delta    = 6'sd0;
    word_nxt = CTRL_00;
    cnt_nxt  = 5'sd0;
    cnt_sum  = 6'sd0;
    if (!vld_p1) begin
      unique case ({vs_p1, hs_p1})
        2'b00:   word_nxt = CTRL_00;
        2'b01:   word_nxt = CTRL_01;
        2'b10:   word_nxt = CTRL_10;
        default: word_nxt = CTRL_11;
      endcase
    end else begin
      if ((cnt_p2 == 5'sd0) || (n1_p1 == n0_p1)) begin
        word_nxt = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
        delta    = qm_p1[8] ? diff : -diff;
      end else if (((cnt_p2 > 5'sd0) && (n1_p1 > n0_p1)) ||
                   ((cnt_p2 < 5'sd0) && (n0_p1 > n1_p1))) begin
        word_nxt = {1'b1, qm_p1[8], ~qm_p1[7:0]};
        delta    = (qm_p1[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        word_nxt = {1'b0, qm_p1[8], qm_p1[7:0]};
        delta    = diff - (qm_p1[8] ? 6'sd0 : 6'sd2);
      end
      cnt_sum = {cnt_p2[4], cnt_p2} + delta;
      cnt_nxt = signed'(cnt_sum[4:0]);
    end
  end

  // Stage-2 register: output word, aligned timing flags, disparity state
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmds_word   <= CTRL_00;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      cnt_p2      <= 5'sd0;
    end else begin
      tmds_word   <= word_nxt;
      de          <= vld_p1;
      hsync       <= hs_p1;
      vsync       <= vs_p1;
      frame_start <= fs_p1;
      cnt_p2      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dvi_blue_tx.sv
// Scoreboard bench for dvi_blue_tx in 640x480 mode: a raster/TMDS model
// queues the expected output for every driven cycle; entries are popped
// and compared as the DUT produces them two edges later.
module tb_dvi_blue_tx;

  logic        clk;
  logic        rst;
  logic [7:0]  pixel_b;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [9:0]  tmds_word;
  logic        de, hsync, vsync, frame_start;

  dvi_blue_tx #(.RESOLUTION(480)) dut (
    .clk(clk), .rst(rst), .pixel_b(pixel_b),
    .hcount(hcount), .vcount(vcount), .tmds_word(tmds_word),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_ZERO = 0, M_FF = 1, M_RAND = 2, M_GRAD = 3;

  typedef struct {
    logic [9:0] word;
    logic       de, hs, vs, fs;
    int         x, y, mode;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mh = 0, mv = 0, mcnt = 0;
  bit   started = 0;
  int   hs_line0 = 0;
  int   fs_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference raster + TMDS encoder written directly from the timing tables
  function automatic exp_t model(input int h, input int v, input logic [7:0] d,
                                 input int mode, inout int cnt);
    exp_t e;
    int n1d, n1, n0;
    logic xn, q8;
    logic [7:0] qm;
    e.x = h; e.y = v; e.mode = mode;
    e.de = (h < 640) && (v < 480);
    e.hs = (h >= 656) && (h < 752);
    e.vs = (v >= 490) && (v < 492);
    e.fs = (h == 0) && (v == 0);
    if (!e.de) begin
      case ({e.vs, e.hs})
        2'b00:   e.word = 10'b1101010100;
        2'b01:   e.word = 10'b0010101011;
        2'b10:   e.word = 10'b0101010100;
        default: e.word = 10'b1010101011;
      endcase
      cnt = 0;
    end else begin
      n1d = $countones(d);
      xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      q8 = ~xn;
      n1 = $countones(qm);
      n0 = 8 - n1;
      if (cnt == 0 || n1 == n0) begin
        e.word = {~q8, q8, q8 ? qm : ~qm};
        cnt += q8 ? (n1 - n0) : (n0 - n1);
      end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
        e.word = {1'b1, q8, ~qm};
        cnt += 2 * int'(q8) + n0 - n1;
      end else begin
        e.word = {1'b0, q8, qm};
        cnt += n1 - n0 - 2 * int'(!q8);
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] gen(input int mode, input int h, input int v);
    case (mode)
      M_ZERO:  return 8'h00;
      M_FF:    return 8'hFF;
      M_RAND:  return 8'($urandom);
      default: return 8'(h + v);
    endcase
  endfunction

  // One clock: check counters, drive, advance model, compare popped entry
  task automatic step(input logic rv, input int mode);
    exp_t e, idle;
    logic [9:0] tbl_ff [4];
    tbl_ff[0] = 10'b1000000000; tbl_ff[1] = 10'b0011111111;
    tbl_ff[2] = 10'b0011111111; tbl_ff[3] = 10'b1000000000;
    idle.word = 10'b1101010100; idle.de = 0; idle.hs = 0; idle.vs = 0; idle.fs = 0;
    idle.x = -1; idle.y = -1; idle.mode = -1;
    if (started) begin
      check("hcount", 32'(hcount), mh);
      check("vcount", 32'(vcount), mv);
    end
    rst = rv;
    pixel_b = gen(mode, mh, mv);
    if (!rv) begin
      sb.delete();
      sb.push_back(idle);
      e = idle;
      mh = 0; mv = 0; mcnt = 0;
      started = 1;
    end else begin
      sb.push_back(model(mh, mv, pixel_b, mode, mcnt));
      mh++;
      if (mh == 800) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
      e = sb.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
    check("tmds_word", 32'(tmds_word), 32'(e.word));
    check("de", 32'(de), 32'(e.de));
    check("hsync", 32'(hsync), 32'(e.hs));
    check("vsync", 32'(vsync), 32'(e.vs));
    check("frame_start", 32'(frame_start), 32'(e.fs));
    if (frame_start === 1'b1) fs_seen++;
    if (e.y == 0 && hsync === 1'b1) hs_line0++;
    if (e.de && e.mode == M_ZERO && e.x < 8)
      check("zero_seq", 32'(tmds_word), (e.x % 2 == 1) ? 32'b1111111111 : 32'b0100000000);
    if (e.de && e.mode == M_FF && e.x < 4)
      check("ff_seq", 32'(tmds_word), 32'(tbl_ff[e.x]));
    if (e.y == 0 && (e.x == 655 || e.x == 656 || e.x == 751 || e.x == 752)) begin
      check("hs_edge", 32'(hsync), (e.x == 656 || e.x == 751) ? 32'd1 : 32'd0);
      check("hs_token", 32'(tmds_word),
            (e.x == 656 || e.x == 751) ? 32'b0010101011 : 32'b1101010100);
    end
  endtask

  task automatic run_lines(input int mode, input int n);
    for (int c = 0; c < n * 800; c++) step(1'b1, mode);
  endtask

  initial begin
    rst = 1'b0;
    pixel_b = 8'h00;
    @(negedge clk);
    // Reset held three cycles
    for (int i = 0; i < 3; i++) step(1'b0, M_ZERO);
    // Line 0 zeros, line 1 0xFF, line 2 random, line 3 zeros after residual disparity
    run_lines(M_ZERO, 1);
    run_lines(M_FF, 1);
    run_lines(M_RAND, 1);
    run_lines(M_ZERO, 1);
    // Mid-line reset at hcount 300
    for (int c = 0; c < 300; c++) step(1'b1, M_RAND);
    step(1'b0, M_RAND);
    // Restarted raster
    run_lines(M_ZERO, 1);
    for (int l = 0; l < 40; l++) run_lines((l % 2 == 1) ? M_RAND : M_GRAD, 1);
    check("hsync_cycles_line0", hs_line0, 192);
    check("frame_start_count", fs_seen, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
